// File: rtl/sp1_ram_arb_pkg.sv
// Shared definitions for the sp1_ram arbiter slice.
//   SP1_RAM_AW / SP1_RAM_DW : geometry of the single-port sp1_ram (64 x 32)
//   SP1_ARB_P0 / SP1_ARB_P1 : port indices used to slice the packed per-port buses
//   tag_t                   : response tag carried alongside an access in flight
//   port_onehot()           : port index -> one-hot grant/valid vector
package sp1_ram_arb_pkg;

  localparam int SP1_RAM_AW = 6;
  localparam int SP1_RAM_DW = 32;
  localparam int SP1_ARB_P0 = 0;
  localparam int SP1_ARB_P1 = 1;

  typedef struct packed {
    logic is_read;  // access expects read data back
    logic owner;    // port that issued the access
  } tag_t;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sp1_arb_pick.sv
// 2-way grant picker for sp1_ram_arb.
// Configuration macro: SP1_RAM_ARB_PRIO_EN
//   defined   : fixed priority, port 0 always wins; no pointer input
//   undefined : round-robin, the port not granted last wins a tie
// Ports:
//   req  in  2  per-port request
//   last in  1  index of the port granted most recently (round-robin build only)
//   gnt  out 2  one-hot or zero grant
module sp1_arb_pick
  import sp1_ram_arb_pkg::*;
(
  input  logic [1:0] req,
`ifndef SP1_RAM_ARB_PRIO_EN
  input  logic       last,
`endif
  output logic [1:0] gnt
);

  // NOTE: every signal written in always_comb gets a default first so no path
  // can leave it unassigned, which would infer a latch.
  always_comb begin
    gnt = 2'b00;
`ifdef SP1_RAM_ARB_PRIO_EN
    if (req[SP1_ARB_P0]) begin
      gnt = port_onehot(1'b0);
    end else if (req[SP1_ARB_P1]) begin
      gnt = port_onehot(1'b1);
    end
`else
    unique case (req)
      2'b01, 2'b10: gnt = req;
      // Tie: hand the grant to the port that did not win last time.
      2'b11:        gnt = port_onehot(~last);
      default:      gnt = 2'b00;
    endcase
`endif
  end

endmodule

// File: rtl/sp1_ram_arb.sv
// Round-robin arbiter and sequencer sharing one sp1_ram between two masters.
// At most one access is issued per cycle through registered cs/we/adr/din; read
// data returns two cycles after the grant, tagged to the requesting port.
// Configuration macro: SP1_RAM_ARB_PRIO_EN (fixed priority to port 0, no pointer).
// Ports:
//   clk, rst  clock (rising edge) and asynchronous active-high reset
//   req, we   per-port request / write enable (bit i = port i)
//   adr, din  per-port address / write data, port i at [i*AW +: AW] / [i*DW +: DW]
//   gnt       combinational one-hot/zero grant, same cycle as the accepted request
//   rvalid    per-port read-data valid
//   dout      shared read data, meaningful only with rvalid
//   ram_*     registered command to sp1_ram, ram_dout back from it
module sp1_ram_arb
  import sp1_ram_arb_pkg::*;
#(
  parameter int AW = SP1_RAM_AW,
  parameter int DW = SP1_RAM_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] adr,
  input  logic [2*DW-1:0] din,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   dout,
  output logic            ram_cs,
  output logic            ram_we,
  output logic [AW-1:0]   ram_adr,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

  logic [1:0]    pick_gnt;
  logic          granted;
  logic          win;
  logic          sel_we;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_din;
  tag_t          tag_s1;
  tag_t          tag_s2;

`ifndef SP1_RAM_ARB_PRIO_EN
  logic last;
`endif

  sp1_arb_pick u_pick (
    .req  (req),
`ifndef SP1_RAM_ARB_PRIO_EN
    .last (last),
`endif
    .gnt  (pick_gnt)
  );

  // No grant may be seen while reset is held, even though req is live.
  assign gnt     = rst ? 2'b00 : pick_gnt;
  assign granted = |gnt;
  assign win     = gnt[SP1_ARB_P1];

  // we is masked by the grant so an undriven we on an idle port cannot leak
  // into ram_we.
  assign sel_we  = |(gnt & we);
  assign sel_adr = win ? adr[SP1_ARB_P1*AW +: AW] : adr[SP1_ARB_P0*AW +: AW];
  assign sel_din = win ? din[SP1_ARB_P1*DW +: DW] : din[SP1_ARB_P0*DW +: DW];

  // Issue registers: the RAM sees the winner one cycle after the grant.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_cs  <= 1'b0;
      ram_we  <= 1'b0;
      ram_adr <= '0;
      ram_din <= '0;
    end else begin
      ram_cs <= granted;
      ram_we <= sel_we;
      if (granted) begin
        ram_adr <= sel_adr;
        ram_din <= sel_din;
      end
    end
  end

  // Tag pipe tracks each access to the cycle its read data appears on
  // ram_dout: stage 1 rides with the issued command, stage 2 with the RAM output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
    end else begin
      tag_s1.is_read <= granted & ~sel_we;
      tag_s1.owner   <= win;
      tag_s2         <= tag_s1;
    end
  end

  assign rvalid = tag_s2.is_read ? port_onehot(tag_s2.owner) : 2'b00;
  assign dout   = ram_dout;

`ifndef SP1_RAM_ARB_PRIO_EN
  // Reset value "port 1 won last" makes port 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (granted) begin
      last <= win;
    end
  end
`endif

endmodule

// File: tb/tb_sp1_ram_arb.sv
// Self-checking bench for sp1_ram_arb: includes a behavioural sp1_ram, a
// transaction-level reference model checked every cycle, directed scenarios
// with literal expectations, and a randomized phase with occasional resets.
module tb_sp1_ram_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [11:0] adr;
  logic [63:0] din;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] dout;
  logic        ram_cs;
  logic        ram_we;
  logic [5:0]  ram_adr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  int total = 0;
  int bad   = 0;

  sp1_ram_arb dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .adr      (adr),
    .din      (din),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .dout     (dout),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_adr  (ram_adr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural sp1_ram: 64 x 32, synchronous read, known initial contents.
  logic [31:0] ram_mem [64];
  initial begin
    for (int i = 0; i < 64; i++) ram_mem[i] = 32'h1000_0000 + i;
    ram_dout = '0;
    forever begin
      @(posedge clk);
      if (ram_cs) begin
        if (ram_we) ram_mem[ram_adr] <= ram_din;
        else        ram_dout <= ram_mem[ram_adr];
      end
    end
  end

  // Reference model: arbitration rule, in-order memory image, response queue.
  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rq[$];
  logic [31:0] model_mem [64];
  int          cyc = 0;
  bit          m_last = 1'b1;  // 1: port 1 won last, so port 0 wins a tie
  bit          iss_v = 1'b0;
  bit          iss_we = 1'b0;
  logic [5:0]  iss_adr = '0;
  logic [31:0] iss_din = '0;

  initial begin
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    logic [31:0] exp_d;
    int          p;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h1000_0000 + i;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("rst_gnt", gnt, 0);
        check("rst_cs", ram_cs, 0);
        check("rst_we", ram_we, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_adr", ram_adr, 0);
        check("rst_din", ram_din, 0);
        rq.delete();
        iss_v   = 1'b0;
        iss_we  = 1'b0;
        iss_adr = '0;
        iss_din = '0;
        m_last  = 1'b1;
      end else begin
        // Command issued for last cycle's grant; address/data hold otherwise.
        check("issue_cs", ram_cs, iss_v);
        check("issue_we", ram_we, iss_v & iss_we);
        check("issue_adr", ram_adr, iss_adr);
        check("issue_din", ram_din, iss_din);
        // A write on the bus now lands in the RAM at the coming edge, before
        // any read granted this cycle is performed.
        if (iss_v && iss_we) model_mem[iss_adr] = iss_din;

        exp_rv = 2'b00;
        exp_d  = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          exp_rv = (rq[0].port == 1) ? 2'b10 : 2'b01;
          exp_d  = rq[0].data;
          void'(rq.pop_front());
        end
        check("rvalid", rvalid, exp_rv);
        if (exp_rv != 2'b00) check("dout", dout, exp_d);

`ifdef SP1_RAM_ARB_PRIO_EN
        exp_gnt = req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00);
`else
        if (req == 2'b11) exp_gnt = m_last ? 2'b01 : 2'b10;
        else              exp_gnt = req;
`endif
        check("gnt", gnt, exp_gnt);

        iss_v = (exp_gnt != 2'b00);
        if (iss_v) begin
          p       = exp_gnt[1] ? 1 : 0;
          iss_we  = we[p];
          iss_adr = adr[p*6 +: 6];
          iss_din = din[p*32 +: 32];
          if (!iss_we) rq.push_back('{cyc + 2, p, model_mem[iss_adr]});
          m_last = exp_gnt[1];
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic run_random(input int n);
    logic [1:0] g;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (!req[i] || g[i]) begin
          req[i]          = ($urandom_range(0, 3) != 0);
          we[i]           = 1'($urandom_range(0, 1));
          adr[i*6 +: 6]   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                                        : 6'($urandom_range(0, 7));
          din[i*32 +: 32] = $urandom;
        end
      end
    end
  endtask

  initial begin
    logic [1:0] exp_g  [6];
    logic [1:0] exp_rv [6];
    rst = 1'b0;
    req = '0;
    we  = '0;
    adr = '0;
    din = '0;

    // Reset held with both ports requesting: nothing granted or issued.
    #2 rst = 1'b1;
    req = 2'b11;
    repeat (5) begin
      mid_cycle();
      check("t1_gnt", gnt, 2'b00);
      check("t1_cs", ram_cs, 1'b0);
      check("t1_rvalid", rvalid, 2'b00);
    end
    next_cycle();
    rst = 1'b0;

`ifndef SP1_RAM_ARB_PRIO_EN
    // Both ports read continuously: grants alternate from port 0.
    exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    exp_rv = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    req = 2'b11;
    we  = 2'b00;
    adr = {6'h02, 6'h01};
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      if (k == 4) req = 2'b00;
      mid_cycle();
      check("t3_gnt", gnt, exp_g[k]);
      check("t3_rvalid", rvalid, exp_rv[k]);
      if (exp_rv[k] == 2'b01) check("t3_dout", dout, 32'h1000_0001);
      if (exp_rv[k] == 2'b10) check("t3_dout", dout, 32'h1000_0002);
    end
`else
    // Fixed priority: port 0 wins every tie; port 1 gets in once port 0 drops.
    exp_g  = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
    exp_rv = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
    req = 2'b11;
    we  = 2'b00;
    adr = {6'h02, 6'h01};
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      if (k == 3) req = 2'b10;
      if (k == 4) req = 2'b00;
      mid_cycle();
      check("t6_gnt", gnt, exp_g[k]);
      check("t6_rvalid", rvalid, exp_rv[k]);
    end
`endif
    next_cycle();

    // P0 writes 0x05 then reads it back.
    next_cycle();
    req = 2'b01; we = 2'b01; adr[5:0] = 6'h05; din[31:0] = 32'hdeadbeef;
    mid_cycle();
    check("t2_wr_gnt", gnt, 2'b01);
    next_cycle();
    we = 2'b00;
    mid_cycle();
    check("t2_rd_gnt", gnt, 2'b01);
    next_cycle();
    req = 2'b00;
    mid_cycle();
    check("t2_rvalid_early", rvalid, 2'b00);
    next_cycle();
    mid_cycle();
    check("t2_rvalid", rvalid, 2'b01);
    check("t2_dout", dout, 32'hdeadbeef);

    // P1 writes 0x3f, P0 reads it the very next cycle.
    next_cycle();
    req = 2'b10; we = 2'b10; adr[11:6] = 6'h3f; din[63:32] = 32'h12345678;
    mid_cycle();
    check("t4_wr_gnt", gnt, 2'b10);
    next_cycle();
    req = 2'b01; we = 2'b00; adr[5:0] = 6'h3f;
    mid_cycle();
    check("t4_rd_gnt", gnt, 2'b01);
    next_cycle();
    req = 2'b00;
    mid_cycle();
    next_cycle();
    mid_cycle();
    check("t4_rvalid", rvalid, 2'b01);
    check("t4_dout", dout, 32'h12345678);

    // Reset lands on a read in flight: command dropped, no response.
    next_cycle();
    req = 2'b01; we = 2'b00; adr[5:0] = 6'h01;
    mid_cycle();
    check("t5_gnt", gnt, 2'b01);
    next_cycle();
    req = 2'b00;
    rst = 1'b1;
    mid_cycle();
    check("t5_cs", ram_cs, 1'b0);
    next_cycle();
    rst = 1'b0;
    mid_cycle();
    check("t5_rvalid", rvalid, 2'b00);
    next_cycle();
    mid_cycle();
    check("t5_rvalid_late", rvalid, 2'b00);

    // Randomized traffic with occasional resets, then drain.
    run_random(3000);
    next_cycle();
    rst = 1'b0;
    req = 2'b00;
    repeat (4) next_cycle();
    mid_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
